// File: rtl/cavlc_pkg.sv
// ----------------------------------------------------------------------------
// cavlc_pkg
//   Shared types and constants for the CAVLC run_before decode path.
//   - rb_state_t          : run_before decoder FSM states
//   - MAX_CW_LEN          : longest run_before codeword (11 bits, run 14)
//   - BLK_SIZE            : coefficients per 4x4 block
//   - RB_LEN_*            : fixed codeword lengths of the short tables
//   - count_leading_zeros : leading-zero count of an 11-bit window (0..11)
// ----------------------------------------------------------------------------
package cavlc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        FIN    = 2'd2
    } rb_state_t;

    localparam int MAX_CW_LEN = 11;
    localparam int BLK_SIZE   = 16;

    // Codeword lengths used by the zerosLeft tables.
    localparam logic [3:0] RB_LEN_1 = 4'd1;
    localparam logic [3:0] RB_LEN_2 = 4'd2;
    localparam logic [3:0] RB_LEN_3 = 4'd3;
    localparam logic [3:0] RB_LEN_MAX = 4'(MAX_CW_LEN);

    // zerosLeft>6 escape codes: k leading zeros (k>=3) encode run k+4 in k+1 bits.
    localparam logic [3:0] RB_ESC_RUN_OFFSET = 4'd4;

    // Number of leading zeros of an MSB-first window; 11 when the window is all zero.
    function automatic logic [3:0] count_leading_zeros(input logic [MAX_CW_LEN-1:0] w);
        logic [3:0] n;
        logic       seen_one;
        n        = 4'd0;
        seen_one = 1'b0;
        for (int i = MAX_CW_LEN - 1; i >= 0; i--) begin
            if (w[i]) begin
                seen_one = 1'b1;
            end else if (!seen_one) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/run_before_lut.sv
// ----------------------------------------------------------------------------
// run_before_lut
//   Combinational run_before codeword table. Looks at the head of the bit
//   window and returns the run it encodes and the codeword length for the
//   current zerosLeft context.
//   Ports:
//     zl      in  4   zeros left (table selector; 0 is not a decode context)
//     win     in  11  bit window, win[10] = next unread bit
//     run     out 4   decoded run_before
//     len     out 4   codeword length in bits
//     invalid out 1   zerosLeft>6 and no '1' in the whole window
// ----------------------------------------------------------------------------
module run_before_lut
    import cavlc_pkg::*;
(
    input  logic [3:0]            zl,
    input  logic [MAX_CW_LEN-1:0] win,
    output logic [3:0]            run,
    output logic [3:0]            len,
    output logic                  invalid
);

    logic [3:0] lz;

    assign lz = count_leading_zeros(win);

    always_comb begin
        run     = 4'd0;
        len     = 4'd0;
        invalid = 1'b0;
        case (zl)
            4'd0: begin
                // No codeword is read when no zeros remain.
                run = 4'd0;
                len = 4'd0;
            end
            4'd1: begin
                len = RB_LEN_1;
                run = win[10] ? 4'd0 : 4'd1;
            end
            4'd2: begin
                if (win[10]) begin
                    len = RB_LEN_1;
                    run = 4'd0;
                end else begin
                    len = RB_LEN_2;
                    run = win[9] ? 4'd1 : 4'd2;
                end
            end
            4'd3: begin
                // 11,10,01,00 -> 0..3
                len = RB_LEN_2;
                run = 4'd3 - {2'b00, win[10:9]};
            end
            4'd4: begin
                if (win[10] | win[9]) begin
                    len = RB_LEN_2;
                    run = 4'd3 - {2'b00, win[10:9]};
                end else begin
                    len = RB_LEN_3;
                    run = win[8] ? 4'd3 : 4'd4;
                end
            end
            4'd5: begin
                if (win[10]) begin
                    len = RB_LEN_2;
                    run = win[9] ? 4'd0 : 4'd1;
                end else begin
                    // 011,010,001,000 -> 2..5
                    len = RB_LEN_3;
                    run = 4'd5 - {2'b00, win[9:8]};
                end
            end
            4'd6: begin
                if (win[10:9] == 2'b11) begin
                    len = RB_LEN_2;
                    run = 4'd0;
                end else begin
                    len = RB_LEN_3;
                    case (win[10:8])
                        3'b000:  run = 4'd1;
                        3'b001:  run = 4'd2;
                        3'b011:  run = 4'd3;
                        3'b010:  run = 4'd4;
                        3'b101:  run = 4'd5;
                        3'b100:  run = 4'd6;
                        default: run = 4'd0;
                    endcase
                end
            end
            default: begin
                // zerosLeft > 6: 111..001 map to runs 0..6; longer codes are
                // k zeros then a one, run k+4 (0001 -> 7 ... 00000000001 -> 14).
                if (lz <= 4'd2) begin
                    len = RB_LEN_3;
                    run = 4'd7 - {1'b0, win[10:8]};
                end else if (lz >= RB_LEN_MAX) begin
                    len     = RB_LEN_MAX;
                    run     = 4'd0;
                    invalid = 1'b1;
                end else begin
                    len = lz + 4'd1;
                    run = lz + RB_ESC_RUN_OFFSET;
                end
            end
        endcase
    end

endmodule

// File: rtl/run_before_decoder.sv
// ----------------------------------------------------------------------------
// run_before_decoder
//   CAVLC run_before decoder for one 4x4 block. After a start pulse it walks
//   the coefficients from highest frequency down, emitting one run and one
//   zig-zag position per cycle and consuming codewords from the bit window.
//   Ports:
//     clk          in   1   clock, rising edge
//     rst          in   1   asynchronous active-low reset
//     start        in   1   begin a block (sampled only in IDLE)
//     totalcoeff   in   5   nonzero coefficient count, 0..16
//     totalzero    in   4   zeros before the last coefficient, 0..15
//     bits_in      in   11  bit window, bits_in[10] = next unread bit
//     bits_avail   in   5   number of valid bits in bits_in, 0..11
//     consume      out  1   source drops consume_len bits this cycle
//     consume_len  out  4   bits consumed (0 when consume=0)
//     run_valid    out  1   run_value/run_pos/run_idx valid
//     run_value    out  4   run_before of current coefficient
//     run_pos      out  4   zig-zag index of current coefficient
//     run_idx      out  5   coefficient ordinal, 0 = highest frequency
//     busy         out  1   not IDLE
//     done         out  1   end-of-block pulse
//     err          out  1   with done: header or bitstream violation
// ----------------------------------------------------------------------------
module run_before_decoder
    import cavlc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            totalcoeff,
    input  logic [3:0]            totalzero,
    input  logic [MAX_CW_LEN-1:0] bits_in,
    input  logic [4:0]            bits_avail,
    output logic                  consume,
    output logic [3:0]            consume_len,
    output logic                  run_valid,
    output logic [3:0]            run_value,
    output logic [3:0]            run_pos,
    output logic [4:0]            run_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    rb_state_t  state_q, state_d;
    logic [3:0] zl_q,    zl_d;
    logic [4:0] pos_q,   pos_d;
    logic [4:0] cnt_q,   cnt_d;
    logic [4:0] tc_q,    tc_d;
    logic       err_r_q, err_r_d;

    logic [3:0] lut_run;
    logic [3:0] lut_len;
    logic       lut_invalid;
    logic [5:0] hdr_sum;
    logic       cw_fits;

    run_before_lut u_lut (
        .zl      (zl_q),
        .win     (bits_in),
        .run     (lut_run),
        .len     (lut_len),
        .invalid (lut_invalid)
    );

    assign hdr_sum = {1'b0, totalcoeff} + {2'b00, totalzero};
    // A codeword is only trusted once all of its bits are inside the window.
    assign cw_fits = ({1'b0, lut_len} <= bits_avail);

    always_comb begin
        state_d     = state_q;
        zl_d        = zl_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        tc_d        = tc_q;
        err_r_d     = err_r_q;
        consume     = 1'b0;
        consume_len = 4'd0;
        run_valid   = 1'b0;
        run_value   = 4'd0;
        run_pos     = 4'd0;
        run_idx     = 5'd0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    zl_d  = totalzero;
                    pos_d = hdr_sum[4:0] - 5'd1;
                    cnt_d = 5'd0;
                    tc_d  = totalcoeff;
                    if (hdr_sum > 6'(BLK_SIZE)) begin
                        err_r_d = 1'b1;
                        state_d = FIN;
                    end else if (totalcoeff == 5'd0) begin
                        err_r_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        state_d = DECODE;
                    end
                end
            end

            DECODE: begin
                if (cnt_q == tc_q - 5'd1) begin
                    // Last (lowest-frequency) coefficient takes all remaining zeros.
                    run_valid = 1'b1;
                    run_value = zl_q;
                    run_pos   = pos_q[3:0];
                    run_idx   = cnt_q;
                    state_d   = FIN;
                end else if (zl_q == 4'd0) begin
                    run_valid = 1'b1;
                    run_value = 4'd0;
                    run_pos   = pos_q[3:0];
                    run_idx   = cnt_q;
                    pos_d     = pos_q - 5'd1;
                    cnt_d     = cnt_q + 5'd1;
                end else if (cw_fits) begin
                    if (lut_invalid || (lut_run > zl_q)) begin
                        err_r_d = 1'b1;
                        state_d = FIN;
                    end else begin
                        run_valid   = 1'b1;
                        run_value   = lut_run;
                        run_pos     = pos_q[3:0];
                        run_idx     = cnt_q;
                        consume     = 1'b1;
                        consume_len = lut_len;
                        zl_d        = zl_q - lut_run;
                        pos_d       = pos_q - {1'b0, lut_run} - 5'd1;
                        cnt_d       = cnt_q + 5'd1;
                    end
                end
                // Otherwise wait for more bits with all outputs idle.
            end

            FIN: begin
                done    = 1'b1;
                err     = err_r_q;
                err_r_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            zl_q    <= 4'd0;
            pos_q   <= 5'd0;
            cnt_q   <= 5'd0;
            tc_q    <= 5'd0;
            err_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zl_q    <= zl_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            err_r_q <= err_r_d;
        end
    end

endmodule

// File: tb/tb_run_before_decoder.sv
// ----------------------------------------------------------------------------
// tb_run_before_decoder
//   Drives blocks into run_before_decoder from a bit-queue source, predicts
//   each block's emits from the codeword tables, and scores the DUT outputs
//   in an independent monitor process.
// ----------------------------------------------------------------------------
module tb_run_before_decoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  totalcoeff;
    logic [3:0]  totalzero;
    logic [10:0] bits_in;
    logic [4:0]  bits_avail;
    logic        consume;
    logic [3:0]  consume_len;
    logic        run_valid;
    logic [3:0]  run_value;
    logic [3:0]  run_pos;
    logic [4:0]  run_idx;
    logic        busy;
    logic        done;
    logic        err;

    run_before_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .totalcoeff  (totalcoeff),
        .totalzero   (totalzero),
        .bits_in     (bits_in),
        .bits_avail  (bits_avail),
        .consume     (consume),
        .consume_len (consume_len),
        .run_valid   (run_valid),
        .run_value   (run_value),
        .run_pos     (run_pos),
        .run_idx     (run_idx),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int run;
        int pos;
        int idx;
        int clen;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    bit   bq[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- codeword tables (zerosLeft, run) -> (len, value) ----------------
    function automatic void cw(input int zl, input int r, output int len, output int val, output bit ok);
        ok = 1'b1; len = 0; val = 0;
        if (zl > 6) begin
            if (r <= 6)       begin len = 3;     val = 7 - r; end
            else if (r <= 14) begin len = r - 3; val = 1;     end
            else ok = 1'b0;
        end else begin
            case (zl)
                1: if (r == 0) begin len = 1; val = 1; end
                   else if (r == 1) begin len = 1; val = 0; end
                   else ok = 1'b0;
                2: if (r == 0) begin len = 1; val = 1; end
                   else if (r <= 2) begin len = 2; val = 2 - r; end
                   else ok = 1'b0;
                3: if (r <= 3) begin len = 2; val = 3 - r; end
                   else ok = 1'b0;
                4: if (r <= 2) begin len = 2; val = 3 - r; end
                   else if (r <= 4) begin len = 3; val = 4 - r; end
                   else ok = 1'b0;
                5: if (r <= 1) begin len = 2; val = 3 - r; end
                   else if (r <= 5) begin len = 3; val = 5 - r; end
                   else ok = 1'b0;
                6: case (r)
                       0: begin len = 2; val = 3; end
                       1: begin len = 3; val = 0; end
                       2: begin len = 3; val = 1; end
                       3: begin len = 3; val = 3; end
                       4: begin len = 3; val = 2; end
                       5: begin len = 3; val = 5; end
                       6: begin len = 3; val = 4; end
                       default: ok = 1'b0;
                   endcase
                default: ok = 1'b0;
            endcase
        end
    endfunction

    function automatic bit match_at(input int off, input int len, input int val);
        for (int b = 0; b < len; b++) begin
            if (off + b >= bq.size()) return 1'b0;
            if (bq[off + b] != bit'((val >> (len - 1 - b)) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push_bits(input int val, input int len);
        for (int b = len - 1; b >= 0; b--) bq.push_back(bit'((val >> b) & 1));
    endfunction

    function automatic void push_random(input int n);
        for (int b = 0; b < n; b++) bq.push_back(bit'($urandom & 1));
    endfunction

    // ---------------- reference decode of the block sitting in bq ----------------
    task automatic model_block(input int tc, input int tz);
        int zl, pos, off, r, len, val;
        bit ok, found;
        exp_t e;
        if (tc + tz > 16) begin err_q.push_back(1); return; end
        if (tc == 0)      begin err_q.push_back(0); return; end
        zl = tz; pos = tc + tz - 1; off = 0;
        for (int i = 0; i < tc; i++) begin
            if (i == tc - 1) begin
                e = '{run: zl, pos: pos, idx: i, clen: 0};
                exp_q.push_back(e);
                err_q.push_back(0);
                return;
            end
            if (zl == 0) begin
                e = '{run: 0, pos: pos, idx: i, clen: 0};
                exp_q.push_back(e);
                pos = pos - 1;
            end else begin
                found = 1'b0; r = 0;
                for (int rr = 0; rr <= 14; rr++) begin
                    cw(zl, rr, len, val, ok);
                    if (!found && ok && match_at(off, len, val)) begin
                        found = 1'b1; r = rr;
                    end
                end
                if (!found || r > zl) begin err_q.push_back(1); return; end
                cw(zl, r, len, val, ok);
                e = '{run: r, pos: pos, idx: i, clen: len};
                exp_q.push_back(e);
                off = off + len; zl = zl - r; pos = pos - r - 1;
            end
        end
    endtask

    // ---------------- bit source ----------------
    task automatic drive_window(input int cap);
        int avail;
        avail = (bq.size() < cap) ? bq.size() : cap;
        for (int k = 0; k < 11; k++)
            bits_in[10 - k] = (k < avail) ? bq[k] : 1'($urandom & 1);
        bits_avail = 5'(avail);
    endtask

    task automatic drop_bits(input int n);
        for (int j = 0; j < n; j++) if (bq.size() > 0) void'(bq.pop_front());
    endtask

    // Issue start, then feed bits until done (bounded).
    task automatic run_block(input int tc, input int tz, input int stall_n, input bit throttle);
        int  cyc, cap;
        bit  seen;
        @(negedge clk);
        totalcoeff = 5'(tc); totalzero = 4'(tz); start = 1'b1;
        drive_window(11);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && ($urandom_range(0, 15) == 0)) begin
                // Must be ignored while busy.
                start = 1'b1;
                totalcoeff = 5'($urandom_range(0, 31));
                totalzero  = 4'($urandom_range(0, 15));
            end
            cap = 11;
            if (cyc < stall_n) cap = 1;
            else if (throttle && $urandom_range(0, 9) < 3) cap = $urandom_range(0, 10);
            drive_window(cap);
            #1;
            if (consume) drop_bits(int'(consume_len));
            if (done) seen = 1'b1;
            cyc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL block_timeout tc=%0d tz=%0d: done not seen within %0d cycles", tc, tz, cyc);
        end
        @(negedge clk);
        start = 1'b0;
        bq.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        int   ee;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                if (run_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_emit got run=%0d pos=%0d idx=%0d, expected no emit",
                                 run_value, run_pos, run_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(run_value) != e.run || int'(run_pos) != (e.pos & 15) ||
                            int'(run_idx) != e.idx || consume != (e.clen != 0) ||
                            int'(consume_len) != e.clen) begin
                            errors++;
                            $display("FAIL emit got run=%0d pos=%0d idx=%0d consume=%0d len=%0d, expected run=%0d pos=%0d idx=%0d len=%0d",
                                     run_value, run_pos, run_idx, consume, consume_len,
                                     e.run, e.pos & 15, e.idx, e.clen);
                        end
                    end
                end else begin
                    checks++;
                    if (consume || consume_len != 4'd0) begin
                        errors++;
                        $display("FAIL idle_consume got consume=%0d len=%0d, expected 0 0", consume, consume_len);
                    end
                end
                if (done) begin
                    checks++;
                    if (err_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done got done=1, expected 0");
                    end else begin
                        ee = err_q.pop_front();
                        if (exp_q.size() != 0) begin
                            errors++;
                            $display("FAIL missing_emits got done with %0d emits pending, expected 0", exp_q.size());
                            exp_q.delete();
                        end
                        if (int'(err) != ee) begin
                            errors++;
                            $display("FAIL done_err got err=%0d, expected %0d", err, ee);
                        end
                    end
                end else begin
                    checks++;
                    if (err) begin
                        errors++;
                        $display("FAIL err_without_done got err=1, expected 0");
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_outputs_zero(input string name);
        checks++;
        if (consume || consume_len != 0 || run_valid || run_value != 0 || run_pos != 0 ||
            run_idx != 0 || busy || done || err) begin
            errors++;
            $display("FAIL %s got consume=%0d len=%0d valid=%0d run=%0d pos=%0d idx=%0d busy=%0d done=%0d err=%0d, expected all 0",
                     name, consume, consume_len, run_valid, run_value, run_pos, run_idx, busy, done, err);
        end
    endtask

    task automatic load_case1();
        bq.delete();
        push_bits(6'b101101, 6);
        push_bits(0, 5);
    endtask

    task automatic legal_block(input bit throttle);
        int tc, tz, zl, r, len, val;
        bit ok;
        tc = $urandom_range(1, 16);
        tz = $urandom_range(0, 16 - tc);
        zl = tz;
        bq.delete();
        for (int i = 0; i < tc - 1; i++) begin
            if (zl != 0) begin
                r = $urandom_range(0, (zl < 14) ? zl : 14);
                cw(zl, r, len, val, ok);
                push_bits(val, len);
                zl = zl - r;
            end
        end
        push_random(11);
        model_block(tc, tz);
        run_block(tc, tz, 0, throttle);
    endtask

    initial begin
        int tc, tz;
        rst = 1'b0; start = 1'b0; totalcoeff = 5'd0; totalzero = 4'd0;
        bits_in = 11'd0; bits_avail = 5'd0;
        #3;
        check_outputs_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("idle_after_reset");

        // Case 1: tc=5 tz=3, 101101 then zeros.
        load_case1();
        model_block(5, 3);
        run_block(5, 3, 0, 1'b0);

        // Case 2: no zeros, three runs of 0.
        bq.delete(); push_random(11);
        model_block(3, 0);
        run_block(3, 0, 0, 1'b0);

        // Case 3: long escape code 0000001.
        bq.delete(); push_bits(1, 7); push_random(4); push_random(11);
        model_block(2, 10);
        run_block(2, 10, 0, 1'b0);

        // Case 4: case 1 with a 3-cycle starvation.
        load_case1();
        model_block(5, 3);
        run_block(5, 3, 3, 1'b0);

        // Case 5: header violation, then an all-zero window at zl=8.
        bq.delete(); push_random(11);
        model_block(10, 8);
        run_block(10, 8, 0, 1'b0);
        bq.delete(); push_bits(0, 16);
        model_block(3, 8);
        run_block(3, 8, 0, 1'b0);

        // Empty block and a run larger than zerosLeft (zl=7, code 00001 = run 8).
        bq.delete(); push_random(11);
        model_block(0, 5);
        run_block(0, 5, 0, 1'b0);
        bq.delete(); push_bits(1, 5); push_random(11);
        model_block(2, 7);
        run_block(2, 7, 0, 1'b0);

        // Case 6: reset in the middle of a block, then case 1 again.
        load_case1();
        model_block(5, 3);
        @(negedge clk);
        totalcoeff = 5'd5; totalzero = 4'd3; start = 1'b1;
        drive_window(11);
        @(negedge clk);
        start = 1'b0;
        drive_window(11);
        #1;
        if (consume) drop_bits(int'(consume_len));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_reset_mid_block");
        exp_q.delete(); err_q.delete(); bq.delete();
        @(negedge clk);
        rst = 1'b1;
        load_case1();
        model_block(5, 3);
        run_block(5, 3, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    tc = $urandom_range(0, 31);
                    tz = $urandom_range(0, 15);
                    if (tc + tz <= 16) tz = 16 - tc + 1 > 15 ? 15 : 16 - tc + 1;
                    bq.delete(); push_random(11);
                    model_block(tc, tz);
                    run_block(tc, tz, 0, 1'b1);
                end
                1, 2: begin
                    tc = $urandom_range(2, 16);
                    tz = $urandom_range(0, 16 - tc);
                    bq.delete(); push_random(200);
                    model_block(tc, tz);
                    run_block(tc, tz, 0, 1'b1);
                end
                default: legal_block(1'b1);
            endcase
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d emits and %0d dones pending, expected 0 0",
                     exp_q.size(), err_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
